// File: rtl/alu_pkg.sv
// Shared types for the arbitrated ALU: opcode encodings, result-register state, opcode check.
// Latency: none (declarations only).
// Backpressure: not applicable.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // True for the five encodings the ALU implements; 011/100/101 are reserved.
    function automatic logic op_legal(input logic [2:0] f);
        logic ok;
        case (f)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: ok = 1'b1;
            default:                                    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: AND/OR/ADD/SUB/SLT, reserved opcodes produce zero.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to capture the result.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       f,
    output logic [WIDTH-1:0] out,
    output logic             zero
);

    // Opcode decode; add/sub wrap naturally at WIDTH bits.
    always_comb begin
        out = '0;
        case (f)
            ALU_AND: out = a & b;
            ALU_OR:  out = a | b;
            ALU_ADD: out = a + b;
            ALU_SUB: out = a - b;
            ALU_SLT: out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: out = '0;
        endcase
    end

    assign zero = (out == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU with a one-entry result register.
// Latency: result visible one cycle after the accepting edge; one result per cycle sustained.
// Backpressure: result held and both readies low while full and rsp_ready low; drain-and-refill allowed.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_f,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_f,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_zero,
    output logic             rsp_id,
    output logic             rsp_err
);

    state_t           state;
    logic             last_gnt;    // requester granted at the most recent accept
    logic             can_accept;
    logic             accept;
    logic             sel;         // requester being granted this cycle
    logic [WIDTH-1:0] mux_a;
    logic [WIDTH-1:0] mux_b;
    logic [2:0]       mux_f;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zero;

    // Grant: a lone requester wins; under contention the one not granted last wins.
    // Reset gates the readies so nothing is handshaken while rst_n is low.
    always_comb begin
        can_accept = rst_n && ((state == ST_EMPTY) || rsp_ready);
        req0_ready = can_accept && req0_valid && (!req1_valid || last_gnt);
        req1_ready = can_accept && req1_valid && (!req0_valid || !last_gnt);
        accept     = req0_ready || req1_ready;
        sel        = req1_ready;
    end

    // Operand mux feeding the shared ALU.
    always_comb begin
        mux_a = sel ? req1_a : req0_a;
        mux_b = sel ? req1_b : req0_b;
        mux_f = sel ? req1_f : req0_f;
    end

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a    (mux_a),
        .b    (mux_b),
        .f    (mux_f),
        .out  (alu_out),
        .zero (alu_zero)
    );

    // Result register and EMPTY/FULL state; fields only change on an accept, so a
    // stalled result is held regardless of what the requesters do meanwhile.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            last_gnt <= 1'b1;
            rsp_out  <= '0;
            rsp_zero <= 1'b0;
            rsp_id   <= 1'b0;
            rsp_err  <= 1'b0;
        end else if (accept) begin
            state    <= ST_FULL;
            last_gnt <= sel;
            rsp_out  <= alu_out;
            rsp_zero <= alu_zero;
            rsp_id   <= sel;
            rsp_err  <= !op_legal(mux_f);
        end else if (rsp_ready) begin
            state    <= ST_EMPTY;
        end
    end

    assign rsp_valid = (state == ST_FULL);

endmodule
